// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: zeroes x1..x31 after reset, then round-robins two sources onto the write port.
// Write port is registered (1-cycle latency); a source stalls simply by seeing ready=0 and must hold its request.
module rf_wb_arbiter #(
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic        init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        ptr;
    logic        grant1;
    logic        run_en;
    logic        xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Source 1 wins when it is alone, or when both contend and the pointer favours it.
    always_comb begin
        grant1   = req1_valid && (!req0_valid || ptr);
        run_en   = (state == RUN) && !reset;
        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = run_en && req0_valid && !grant1;
    assign req1_ready = run_en && req1_valid && grant1;
    assign xfer       = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= (INIT_ZERO != 0) ? INIT : RUN;
            cnt       <= 5'd1;
            ptr       <= 1'b0;
            we3       <= 1'b0;
            a3        <= 5'd0;
            wd3       <= 32'd0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            we3 <= 1'b1;
            a3  <= cnt;
            wd3 <= 32'd0;
            if (cnt == 5'd31) begin
                state     <= RUN;
                init_done <= 1'b1;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end else begin
            init_done <= 1'b1;
            if (xfer) begin
                // x0 is hardwired zero: handshake completes but the write is suppressed.
                we3 <= (sel_addr != 5'd0);
                a3  <= sel_addr;
                wd3 <= (sel_addr != 5'd0) ? sel_data : 32'd0;
                ptr <= ~grant1;
            end else begin
                we3 <= 1'b0;
                a3  <= 5'd0;
                wd3 <= 32'd0;
            end
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter INIT_ZERO, default 1; 1 = zero x1..x31 after reset, 0 = skip the zeroing sequence.
REQ-002 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid, req1_valid, input, 1 bit each; writeback request from source 0 (ALU path) and source 1 (load/multicycle path).
REQ-005 SHALL have ports req0_addr, req1_addr, input, 5 bits each; destination register.
REQ-006 SHALL have ports req0_data, req1_data, input, 32 bits each; write data.
REQ-007 SHALL have ports req0_ready, req1_ready, output, 1 bit each; request accepted this cycle.
REQ-008 SHALL have ports we3, a3 and wd3, output, 1/5/32 bits; drive the register file write port directly.
REQ-009 SHALL have port init_done, output, 1 bit; high once arbitration is enabled.

Function
REQ-010 SHALL implement a 2-state FSM: INIT (zeroing) and RUN (arbitration).
REQ-011 SHALL enter INIT on reset when INIT_ZERO=1, else RUN.
REQ-012 SHALL, in INIT, issue one write per cycle with a3 = counter and wd3 = 0.
REQ-013 SHALL start the INIT counter at 1 and stop it at 31: exactly 31 writes, never to x0.
REQ-014 SHALL, in INIT, transition to RUN on the edge that issues the a3=31 write.
REQ-015 SHALL hold req0_ready and req1_ready at 0 throughout INIT, regardless of valid.
REQ-016 SHALL drive init_done as a register equal to (state == RUN).
REQ-017 SHALL compute readys combinationally in RUN: reqN_ready = reqN_valid AND grant to N.
REQ-018 SHALL constitute a transfer on source N when reqN_valid and reqN_ready are both high at a rising edge.
REQ-019 SHALL grant the lone requester when exactly one source is valid.
REQ-020 SHALL grant the source selected by a round-robin pointer when both are valid.
REQ-021 SHALL reset the round-robin pointer to source 0.
REQ-022 SHALL, after each transfer from source N, point the round-robin pointer at the other source.
REQ-023 SHALL accept at most one transfer per cycle; the losing source sees ready=0.
REQ-024 SHALL register the write port outputs: a transfer at edge E drives we3=1, a3=addr and wd3=data for the cycle after E. Latency is 1 cycle.
REQ-025 SHALL, for a transfer with addr == 0, complete the handshake but drive we3=0 in the following cycle (x0 never written).
REQ-026 SHALL, in a cycle with no transfer or INIT write on the preceding edge, drive we3=0, a3=0 and wd3=0.
REQ-027 SHALL expect requesters to hold addr and data stable while valid is high and ready is low; the block does not buffer unaccepted requests.
REQ-028 SHALL accept back-to-back transfers every cycle, alternating sources under continuous contention.

Reset
REQ-029 SHALL drive we3=0, a3=0, wd3=0, init_done=0, both readys=0, pointer=0 and INIT counter=1 while reset is high.
REQ-030 SHALL, on reset asserted mid-INIT or mid-RUN, abort the current state at the next edge.
REQ-031 SHALL discard any registered but undriven write on that reset.
REQ-032 SHALL restart the zeroing sequence from x1 after reset when INIT_ZERO=1.

Verification
REQ-033 Bench SHALL cover: reset released, INIT_ZERO=1 -> we3=1 for exactly 31 consecutive cycles with a3 = 1..31 and wd3=0; then init_done=1; no ready during that window.
REQ-034 Bench SHALL cover: RUN, only req1_valid with addr=5, data=0xDEADBEEF -> req1_ready=1 same cycle; next cycle we3=1, a3=5, wd3=0xDEADBEEF.
REQ-035 Bench SHALL cover: both valid continuously for 4 cycles from reset pointer -> grants 0,1,0,1; write port shows matching addr/data 1 cycle later each.
REQ-036 Bench SHALL cover: req0 transfer with addr=0, data=0x1234 -> ready=1; next cycle we3=0.
REQ-037 Bench SHALL cover: reset pulsed during INIT at a3=12 -> we3=0 during reset; sequence restarts at a3=1 and runs the full 31 writes.
REQ-038 Bench SHALL cover: INIT_ZERO=0 -> init_done=1 on the first cycle after reset; a request in that cycle is accepted immediately.
